lockable_bank_ctrl: RTL
=======================

Name: lockable_bank_ctrl

Overview:
Write controller for a bank of sticky-lock configuration registers, each 8 bits wide.
NREQ requesters share one write path. A round-robin arbiter grants one write at a time. A per-register lock bit, once set, blocks all further writes until reset.
The block sits between bus-side requesters and the locked configuration state. It also exposes register contents and lock status to downstream logic.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 2, register address width; bank holds NREG = 2**AW registers
DW, 8, register data width

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  reset; synchronous, active-low (sampled on rising clk edge)
req  input  NREQ  per-requester write request; level, held until done
req_addr  input  NREQ*AW  per-requester target address, slice i = [i*AW +: AW]
req_wdata  input  NREQ*DW  per-requester write data, slice i = [i*DW +: DW]
req_lock  input  NREQ  per-requester flag: lock the target register after this write
lock_all  input  1  sticky lock of every register; pulse or level
done  output  NREQ  one-hot, one-cycle completion pulse to the served requester
err  output  1  valid with done; 1 = write rejected because the target was locked
busy  output  1  high whenever the FSM is not in IDLE
lock_status  output  NREG  current lock bit per register
reg_out  output  NREG*DW  all register contents, slice r = [r*DW +: DW]

Behaviour:
- Reset (rst_n=0 at an edge) clears the following from any state, including mid-transaction:
  - all registers to 0 and all lock bits to 0
  - done=0, err=0, busy=0
  - state=IDLE and RR pointer=0
  - any latched request is discarded and no done is issued for it
- FSM states:
  - IDLE:
    - If |req, select a winner and latch its addr, wdata and lock flag.
    - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod NREQ.
    - Go to EXEC. Otherwise stay in IDLE.
  - EXEC:
    - Evaluate the lock as locked = lock_bit[addr] OR lock_all (lock_all sampled in this same cycle).
    - If not locked: reg[addr] <= wdata, and lock_bit[addr] <= 1 when the latched lock flag is set. err <= 0.
    - If locked: no register change; err <= 1.
    - done[winner] <= 1; ptr <= (winner+1) mod NREQ.
    - Go to RESP.
  - RESP:
    - done and err are visible for exactly this one cycle. Go to IDLE; done and err clear at the next edge.
- Requester rules:
  - Hold req, addr, wdata and lock stable from assertion until done is seen.
  - Drive req low at the edge that ends the done cycle.
  - The controller samples req again only in IDLE.
- Latency: req first seen in IDLE at cycle T gives the register update at the edge ending T+1 and done during T+2. Minimum spacing between grants is 3 cycles.
- lock_all: at any edge where it is high, every lock bit is set. This is independent of FSM state and never clears before reset.
- A lock, once set, is sticky. No input clears it except rst_n.
- Writing a locked register with req_lock=1 still gives err=1 and changes nothing.
- A request deasserted before grant is simply not served. Deasserting after grant is a protocol violation; the write still completes.
- Outputs:
  - reg_out and lock_status are driven directly from flops, with no combinational path from the inputs.
  - done, err and busy are registered.

Test Plan:
1. Reset, then req[0]=1, addr=2, wdata=0x5A, lock=0 -> done[0] pulses 2 cycles later with err=0; reg_out slice 2 = 0x5A; lock_status=0000.
2. Write addr=1, data=0x11, lock=1, then a second write addr=1, data=0x22 -> first: err=0, slice1=0x11, lock_status[1]=1; second: err=1, slice1 stays 0x11.
3. req=1111 held continuously, each requester dropping after its done -> grants in order 0,1,2,3. Then re-raise req[0] and req[3] -> grant order 0,3 (pointer at 0 after 3).
4. Pulse lock_all for 1 cycle during EXEC of a write of 0x77 to unlocked addr 3 -> err=1, slice3 unchanged, lock_status=1111.
5. Assert rst_n=0 during EXEC of a lock write -> no done pulse; all registers 0, lock_status=0000, busy=0. A subsequent write to the same addr succeeds with err=0.
6. Lock every register, then rst_n=0 for 1 cycle -> all lock bits clear. A write of 0xA5 to addr 0 succeeds and reg_out slice 0 = 0xA5.

Source files
------------

// File: rtl/lockable_bank_ctrl.sv
// Sticky-lock configuration register bank with a round-robin
// arbitrated, single-port write path shared by NREQ requesters.
module lockable_bank_ctrl #(
   parameter int NREQ = 4,
   parameter int AW   = 2,
   parameter int DW   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ*DW-1:0]       req_wdata,
   input  logic [NREQ-1:0]          req_lock,
   input  logic                     lock_all,
   output logic [NREQ-1:0]          done,
   output logic                     err,
   output logic                     busy,
   output logic [(2**AW)-1:0]       lock_status,
   output logic [(2**AW)*DW-1:0]    reg_out
);

   localparam int NREG = 2**AW;
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_n;

   logic [IW-1:0]     ptr;
   logic [IW-1:0]     nxt_ptr;
   logic [IW-1:0]     win;
   logic              found;
   logic [IW:0]       sum;
   logic [IW-1:0]     idx;

   logic [IW-1:0]     w_q;
   logic [AW-1:0]     a_q;
   logic [DW-1:0]     d_q;
   logic              lk_q;

   logic              take;
   logic              wr_en;
   logic              locked;
   logic              err_n;
   logic [NREQ-1:0]   done_n;

   logic [DW-1:0]     regs [NREG];
   logic [NREG-1:0]   lock_bits;

   // Rotating-priority scan starting at ptr; first requester wins.
   always_comb begin
      win   = ptr;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
         end
         idx = sum[IW-1:0];
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign nxt_ptr = (w_q == IW'(NREQ-1)) ? '0 : w_q + 1'b1;

   // Next-state and next-output decode for the write FSM.
   always_comb begin
      state_n = state;
      take    = 1'b0;
      wr_en   = 1'b0;
      err_n   = 1'b0;
      done_n  = '0;
      locked  = lock_bits[a_q] | lock_all;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_n = EXEC;
               take    = 1'b1;
            end
         end
         EXEC: begin
            state_n     = RESP;
            wr_en       = ~locked;
            err_n       = locked;
            done_n[w_q] = 1'b1;
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, pointer and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         done  <= '0;
         err   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         done  <= done_n;
         err   <= err_n;
         busy  <= (state_n != IDLE);
         if (state == EXEC) begin
            ptr <= nxt_ptr;
         end
      end
   end

   // Capture the winning request so it stays fixed through EXEC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_q  <= '0;
         a_q  <= '0;
         d_q  <= '0;
         lk_q <= 1'b0;
      end else if (take) begin
         w_q  <= win;
         a_q  <= req_addr[win*AW +: AW];
         d_q  <= req_wdata[win*DW +: DW];
         lk_q <= req_lock[win];
      end
   end

   // Register bank; only an unlocked EXEC write changes contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
         end
      end else if (wr_en) begin
         regs[a_q] <= d_q;
      end
   end

   // Sticky lock bits; lock_all overrides in any state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_bits <= '0;
      end else if (lock_all) begin
         lock_bits <= '1;
      end else if (wr_en && lk_q) begin
         lock_bits[a_q] <= 1'b1;
      end
   end

   assign lock_status = lock_bits;

   for (genvar r = 0; r < NREG; r++) begin : g_out
      assign reg_out[r*DW +: DW] = regs[r];
   end

endmodule
